// File: rtl/main_dp.sv
// Matrix-multiply datapath: four output lanes each accumulate one C element per group from quad-port A/B buffers.
// Latency: 1 + ceil(ROW1*COL2/4)*(COL1+2) cycles from reset release to done; no backpressure, RAMs are fixed 1-cycle read.
module main_dp #(
    parameter int WIDTH     = 32,
    parameter int ROW1      = 2,
    parameter int COL1      = 3,
    parameter int ROW2      = 3,
    parameter int COL2      = 5,
    parameter int HEIGHT_IN = 96,
    parameter int HEIGHT_W  = 240,
    parameter int HEIGHT_O  = 160,
    parameter int ROW_PE    = 4,
    parameter int COL_PE    = 4,
    localparam int AW_IN    = $clog2(HEIGHT_IN),
    localparam int AW_W     = $clog2(HEIGHT_W),
    localparam int AW_O     = $clog2(HEIGHT_O)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [ROW1-1:0][COL2-1:0][ROW2-1:0] en,
    input  logic [3:0][WIDTH-1:0]                Data_in,
    input  logic [3:0][WIDTH-1:0]                Data_w,
    output logic [3:0][AW_IN-1:0]                Addr_GBF_in,
    output logic [3:0][AW_W-1:0]                 Addr_GBF_w,
    output logic [3:0][AW_O-1:0]                 Addr_GBF_o,
    output logic [3:0][WIDTH-1:0]                Data_o,
    output logic [3:0]                           we_o,
    output logic                                 done
);

    localparam int NOUT = ROW1 * COL2;
    localparam int G    = (NOUT + 3) / 4;
    localparam int EN_N = ROW1 * COL2 * ROW2;
    localparam int EIW  = (EN_N > 1) ? $clog2(EN_N) : 1;

    if (COL1 != ROW2) begin : g_bad_inner_dim
        $error("main_dp: COL1 must equal ROW2");
    end
    if (HEIGHT_IN < ROW1 * COL1 || HEIGHT_W < ROW2 * COL2 || HEIGHT_O < NOUT) begin : g_bad_depth
        $error("main_dp: buffer depth too small for matrix dimensions");
    end
    if (ROW_PE * COL_PE < 4) begin : g_bad_pe
        $error("main_dp: PE grid must provide at least 4 lanes");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] grp, grp_nxt;
    logic [15:0] k, k_nxt;
    logic [EN_N-1:0] en_flat;

    assign en_flat = en;
    assign done    = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grp   <= '0;
            k     <= '0;
        end else begin
            state <= state_nxt;
            grp   <= grp_nxt;
            k     <= k_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grp_nxt   = grp;
        k_nxt     = k;
        case (state)
            IDLE: begin
                state_nxt = READ;
                grp_nxt   = '0;
                k_nxt     = '0;
            end
            READ: begin
                if (k == 16'(COL1 - 1)) begin
                    state_nxt = DRAIN;
                    k_nxt     = '0;
                end else begin
                    k_nxt = k + 16'd1;
                end
            end
            DRAIN: state_nxt = WRITE;
            WRITE: begin
                if (grp == 16'(G - 1)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = READ;
                    grp_nxt   = grp + 16'd1;
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [31:0]      n, li, lj;
        logic             valid, en_bit, term_vld, term_q;
        logic [WIDTH-1:0] acc;

        always_comb begin
            n      = 32'(grp) * 32'd4 + 32'(l);
            valid  = (n < 32'(NOUT));
            li     = n / 32'(COL2);
            lj     = n % 32'(COL2);
            en_bit = valid ? en_flat[EIW'((li * 32'(COL2) + lj) * 32'(ROW2) + 32'(k))] : 1'b0;
        end

        assign term_vld = (state == READ) && valid && en_bit;

        always_comb begin
            Addr_GBF_in[l] = '0;
            Addr_GBF_w[l]  = '0;
            Addr_GBF_o[l]  = '0;
            Data_o[l]      = '0;
            we_o[l]        = 1'b0;
            if (state == READ && valid) begin
                Addr_GBF_in[l] = AW_IN'(li * 32'(COL1) + 32'(k));
                Addr_GBF_w[l]  = AW_W'(32'(k) * 32'(COL2) + lj);
            end
            if (state == WRITE && valid) begin
                Addr_GBF_o[l] = AW_O'(n);
                Data_o[l]     = acc;
                we_o[l]       = 1'b1;
            end
        end

        // term_q marks the cycle in which RAM data for this lane's enabled term is present
        always_ff @(posedge clk) begin
            if (rst) begin
                term_q <= 1'b0;
                acc    <= '0;
            end else begin
                term_q <= term_vld;
                if (state == IDLE || state == WRITE) begin
                    acc <= '0;
                end else if (term_q) begin
                    acc <= acc + Data_in[l] * Data_w[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_main_dp.sv
// Bench for main_dp: behavioural quad-port RAMs around the datapath, directed matrices with hand-computed C.
module tb_main_dp;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [1:0][4:0][2:0]    en;
    logic [3:0][31:0]        Data_in, Data_w;
    logic [3:0][6:0]         Addr_GBF_in;
    logic [3:0][7:0]         Addr_GBF_w;
    logic [3:0][7:0]         Addr_GBF_o;
    logic [3:0][31:0]        Data_o;
    logic [3:0]              we_o;
    logic                    done;

    logic [31:0] mem_a [0:95];
    logic [31:0] mem_b [0:239];
    logic [31:0] mem_c [0:159];
    logic        clr_c = 1'b1;
    int          wr_cnt;
    int          compared = 0;
    int          mismatched = 0;
    int          cyc;

    localparam logic [31:0] SENT = 32'hDEAD_BEEF;
    logic [31:0] exp1 [0:9] = '{46, 52, 58, 64, 70, 100, 115, 130, 145, 160};

    main_dp dut (
        .clk(clk), .rst(rst), .en(en),
        .Data_in(Data_in), .Data_w(Data_w),
        .Addr_GBF_in(Addr_GBF_in), .Addr_GBF_w(Addr_GBF_w), .Addr_GBF_o(Addr_GBF_o),
        .Data_o(Data_o), .we_o(we_o), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            Data_in[l] <= mem_a[Addr_GBF_in[l]];
            Data_w[l]  <= mem_b[Addr_GBF_w[l]];
        end
        if (clr_c) begin
            for (int a = 0; a < 160; a++) mem_c[a] <= SENT;
            wr_cnt <= 0;
        end else begin
            for (int l = 0; l < 4; l++)
                if (we_o[l]) mem_c[Addr_GBF_o[l]] <= Data_o[l];
            wr_cnt <= wr_cnt + $countones(we_o);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_case1();
        for (int a = 0; a < 96; a++) mem_a[a] = '0;
        for (int a = 0; a < 240; a++) mem_b[a] = '0;
        for (int a = 0; a < 6; a++) mem_a[a] = 32'(a + 1);
        for (int a = 0; a < 15; a++) mem_b[a] = 32'(a + 1);
    endtask

    // Called at a negedge; returns edges from reset release until done is seen high.
    task automatic run_once(output int n);
        clr_c = 1'b1;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        clr_c = 1'b0;
        rst   = 1'b0;
        n     = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"},   64'(we_o), 64'd0);
        check({tag, "_ain"},  64'(Addr_GBF_in), 64'd0);
        check({tag, "_aw"},   64'(Addr_GBF_w), 64'd0);
        check({tag, "_ao"},   64'(Addr_GBF_o), 64'd0);
        check({tag, "_dat"},  64'(Data_o), 64'd0);
    endtask

    initial begin
        en = '1;
        load_case1();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", 64'(done), 64'd0);
        check_idle_outputs("rst");
        @(negedge clk);

        // case 1: full enable
        run_once(cyc);
        check("c1_cycles", 64'(cyc), 64'd16);
        @(negedge clk);
        for (int a = 0; a < 10; a++) check($sformatf("c1_C%0d", a), 64'(mem_c[a]), 64'(exp1[a]));
        check("c1_wr_cnt", 64'(wr_cnt), 64'd10);
        for (int a = 10; a < 16; a++) check($sformatf("c1_unwr%0d", a), 64'(mem_c[a]), 64'(SENT));
        check("c1_done_sticky", 64'(done), 64'd1);
        check_idle_outputs("c1_done");

        // case 2: single term masked
        en = '1;
        en[0][0][1] = 1'b0;
        run_once(cyc);
        @(negedge clk);
        check("c2_C0", 64'(mem_c[0]), 64'd34);
        for (int a = 1; a < 10; a++) check($sformatf("c2_C%0d", a), 64'(mem_c[a]), 64'(exp1[a]));

        // case 3: everything masked
        en = '0;
        run_once(cyc);
        check("c3_cycles", 64'(cyc), 64'd16);
        @(negedge clk);
        for (int a = 0; a < 10; a++) check($sformatf("c3_C%0d", a), 64'(mem_c[a]), 64'd0);
        check("c3_unwr10", 64'(mem_c[10]), 64'(SENT));
        check("c3_wr_cnt", 64'(wr_cnt), 64'd10);

        // case 4: product wraps to zero
        en = '1;
        for (int a = 0; a < 96; a++) mem_a[a] = '0;
        for (int a = 0; a < 240; a++) mem_b[a] = '0;
        mem_a[0] = 32'h0001_0000;
        mem_b[0] = 32'h0001_0000;
        run_once(cyc);
        @(negedge clk);
        check("c4_C0_wrap", 64'(mem_c[0]), 64'd0);
        check("c4_C5", 64'(mem_c[5]), 64'd0);

        // case 5: reset during group 1 READ, then rerun
        load_case1();
        clr_c = 1'b1;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        clr_c = 1'b0;
        rst   = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("c5_g1_ain0", 64'(Addr_GBF_in[0]), 64'd1);
        check("c5_g1_aw0",  64'(Addr_GBF_w[0]), 64'd9);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("c5_rst_done", 64'(done), 64'd0);
        check_idle_outputs("c5_rst");
        @(negedge clk);
        run_once(cyc);
        check("c5_cycles", 64'(cyc), 64'd16);
        @(negedge clk);
        for (int a = 0; a < 10; a++) check($sformatf("c5_C%0d", a), 64'(mem_c[a]), 64'(exp1[a]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
